ray_march_stepper: RTL and testbench
====================================

Name: ray_march_stepper

Overview:
Ray-marching initiator that drives any fixed-latency SDF query pipeline (cube, sponge, infinite sponge). It accepts one ray (origin, unit direction, id) and repeatedly issues sample points p = origin + t·dir. It captures the returned distance and advances t by it until a hit, an escape or a step limit. It sits between the per-pixel ray generator and the shading stage and owns the query side of the SDF interface.

Parameters:
FP_WIDTH, 32, fp word width; Q16.16 two's complement, same fp type as fixed_point_arith.
SDF_LATENCY, 4, cycles from query_valid_out to the matching sdf_in; must be ≥1.
MAX_STEPS, 64, maximum queries per ray.
EPSILON, 32'h0000_0100, hit threshold (raw fp, ~0.0039).
MAX_T, 32'h0020_0000, escape distance (raw fp, 32.0).
ID_WIDTH, 20, ray tag width.

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
ray_valid_in  input  1  ray request valid
ray_ready_out  output  1  high only in IDLE
ray_origin_in  input  3*FP_WIDTH  vec3 origin {x,y,z}
ray_dir_in  input  3*FP_WIDTH  vec3 unit direction
ray_id_in  input  ID_WIDTH  tag
query_point_out  output  3*FP_WIDTH  sample point to SDF module
query_valid_out  output  1  one-cycle query strobe
sdf_in  input  FP_WIDTH  distance from SDF module
res_valid_out  output  1  result valid
res_ready_in  input  1  result accepted
res_hit_out  output  1  1 = surface hit
res_t_out  output  FP_WIDTH  final t
res_steps_out  output  $clog2(MAX_STEPS+1)  queries issued
res_id_out  output  ID_WIDTH  echoed tag

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; ray_ready_out=0 during reset, then 1; query_valid_out=0; res_valid_out=0; res_* =0; query_point_out=0; latency tracker cleared.
- One ray in flight. FSM: IDLE → ISSUE → WAIT → EVAL → (ISSUE | DONE); DONE → IDLE.
- IDLE: ray_ready_out=1. On ray_valid_in && ray_ready_out, latch origin/dir/id, t=0, steps=0 → ISSUE.
- ISSUE (1 cycle): query_point_out = origin + fp_mul(dir, t) per component, registered; query_valid_out=1 this cycle only; steps += 1 → WAIT.
- WAIT: SDF_LATENCY-bit valid shift register tracks the strobe. sdf_in is sampled in the cycle the tracker's tail bit is set. sdf_in is ignored at all other times → EVAL.
- EVAL, priority order:
  - sdf < EPSILON (signed compare, negative counts): hit=1 → DONE; t is not advanced.
  - t_next = t + sdf, saturating at max positive fp. If t_next > MAX_T: hit=0, t=t_next → DONE.
  - steps == MAX_STEPS: hit=0, t=t_next → DONE.
  - Otherwise t=t_next → ISSUE.
- Iteration throughput: 2+SDF_LATENCY cycles per step.
- DONE: res_valid_out=1 with stable outputs until res_ready_in. The handshake cycle → IDLE, clears res_valid_out. ray_ready_out stays 0 until IDLE, so no back-to-back accept in the handshake cycle.
- res_steps_out = number of query strobes for this ray (1..MAX_STEPS).
- Reset mid-ray: all state is dropped. Any SDF result still in the external pipeline is discarded because the tracker is cleared. No res_valid_out is produced for the aborted ray.
- query_valid_out is never high outside ISSUE. At most one query is outstanding.

Test Plan:
- Scripted stub, latency 4. origin (0,0,0), dir (0,0,1.0), sdf_in = 1.0 for the first 3 queries, then 0 → hit=1, t=32'h0003_0000, steps=4, each query point z = 0,1,2,3 (Q16.16), strobes spaced 6 cycles.
- Stub returns constant 4.0. Inject MAX_T crossing → after 9th query t=36.0 > 32.0: hit=0, t=32'h0024_0000, steps=9.
- Stub returns constant 32'h0000_0200, MAX_STEPS=64 → hit=0, steps=64, t=32'h0000_8000, exactly 64 strobes.
- Negative distance (32'hFFFF_0000) on first query → hit=1, t=0, steps=1.
- Hold res_ready_in=0 for 10 cycles at DONE → outputs stable, ray_ready_out=0, no strobes. Then pulse → IDLE next cycle; the next ray is accepted one cycle later.
- Assert rst_n_in low during WAIT for 2 cycles, then restart with a new ray (id=5). The stale sdf_in return is ignored, the first result carries id=5, and there is no result for the aborted ray.

Source files
------------

// File: rtl/ray_march_stepper.sv
// rtl/ray_march_stepper.sv - sphere-tracing stepper that drives a fixed-latency SDF query pipeline
// One ray in flight; each step issues p = origin + t*dir and advances t by the returned distance.
module ray_march_stepper #(
  parameter int                  FP_WIDTH    = 32,
  parameter int                  SDF_LATENCY = 4,
  parameter int                  MAX_STEPS   = 64,
  parameter logic [FP_WIDTH-1:0] EPSILON     = 32'h0000_0100,
  parameter logic [FP_WIDTH-1:0] MAX_T       = 32'h0020_0000,
  parameter int                  ID_WIDTH    = 20,
  localparam int                 STEP_W      = $clog2(MAX_STEPS + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    ray_valid_in,
  output logic                    ray_ready_out,
  input  logic [3*FP_WIDTH-1:0]   ray_origin_in,
  input  logic [3*FP_WIDTH-1:0]   ray_dir_in,
  input  logic [ID_WIDTH-1:0]     ray_id_in,
  output logic [3*FP_WIDTH-1:0]   query_point_out,
  output logic                    query_valid_out,
  input  logic [FP_WIDTH-1:0]     sdf_in,
  output logic                    res_valid_out,
  input  logic                    res_ready_in,
  output logic                    res_hit_out,
  output logic [FP_WIDTH-1:0]     res_t_out,
  output logic [STEP_W-1:0]       res_steps_out,
  output logic [ID_WIDTH-1:0]     res_id_out
);

  localparam int FRAC = 16;
  localparam logic [FP_WIDTH-1:0] FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0] FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

  function automatic logic [FP_WIDTH-1:0] fp_mul(input logic signed [FP_WIDTH-1:0] a,
                                                 input logic signed [FP_WIDTH-1:0] b);
    logic signed [2*FP_WIDTH-1:0] p;
    p = (2*FP_WIDTH)'(a) * (2*FP_WIDTH)'(b);
    return p[FRAC +: FP_WIDTH];
  endfunction

  function automatic logic [3*FP_WIDTH-1:0] sample_point(input logic [3*FP_WIDTH-1:0] o,
                                                         input logic [3*FP_WIDTH-1:0] d,
                                                         input logic [FP_WIDTH-1:0]   t);
    logic [3*FP_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      r[i*FP_WIDTH +: FP_WIDTH] = o[i*FP_WIDTH +: FP_WIDTH] + fp_mul(d[i*FP_WIDTH +: FP_WIDTH], t);
    return r;
  endfunction

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t                  state_q, state_d;
  logic [3*FP_WIDTH-1:0]   origin_q, dir_q, point_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [FP_WIDTH-1:0]     t_q, sdf_q, t_next;
  logic [STEP_W-1:0]       steps_q;
  logic                    hit_q;
  logic [SDF_LATENCY-1:0]  trk_q;
  logic [FP_WIDTH:0]       sum;
  logic                    is_hit, is_escape, is_last, sdf_arrives;

  assign sdf_arrives = trk_q[SDF_LATENCY-1];

  always_comb begin
    sum    = {t_q[FP_WIDTH-1], t_q} + {sdf_q[FP_WIDTH-1], sdf_q};
    t_next = sum[FP_WIDTH-1:0];
    if (sum[FP_WIDTH] != sum[FP_WIDTH-1])
      t_next = sum[FP_WIDTH] ? FP_MIN : FP_MAX;
    is_hit    = $signed(sdf_q) < $signed(EPSILON);
    is_escape = $signed(t_next) > $signed(MAX_T);
    is_last   = steps_q == STEP_W'(MAX_STEPS);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ray_valid_in && ray_ready_out) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (sdf_arrives) state_d = S_EVAL;
      S_EVAL:  state_d = (is_hit || is_escape || is_last) ? S_DONE : S_ISSUE;
      S_DONE:  if (res_ready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      origin_q <= '0;
      dir_q    <= '0;
      point_q  <= '0;
      id_q     <= '0;
      t_q      <= '0;
      sdf_q    <= '0;
      steps_q  <= '0;
      hit_q    <= 1'b0;
      trk_q    <= '0;
    end else begin
      state_q <= state_d;
      trk_q   <= (trk_q << 1) | SDF_LATENCY'(query_valid_out);
      case (state_q)
        S_IDLE: if (ray_valid_in && ray_ready_out) begin
          origin_q <= ray_origin_in;
          dir_q    <= ray_dir_in;
          id_q     <= ray_id_in;
          point_q  <= ray_origin_in;
          t_q      <= '0;
          steps_q  <= '0;
          hit_q    <= 1'b0;
        end
        S_ISSUE: steps_q <= steps_q + STEP_W'(1);
        S_WAIT:  if (sdf_arrives) sdf_q <= sdf_in;
        S_EVAL: begin
          if (is_hit) begin
            hit_q <= 1'b1;
          end else begin
            t_q <= t_next;
            if (!is_escape && !is_last) point_q <= sample_point(origin_q, dir_q, t_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign ray_ready_out   = (state_q == S_IDLE) && rst_n;
  assign query_valid_out = (state_q == S_ISSUE);
  assign query_point_out = point_q;
  assign res_valid_out   = (state_q == S_DONE);
  assign res_hit_out     = hit_q;
  assign res_t_out       = t_q;
  assign res_steps_out   = steps_q;
  assign res_id_out      = id_q;

endmodule

// File: tb/tb_ray_march_stepper.sv
// tb/tb_ray_march_stepper.sv - self-checking bench for ray_march_stepper with a scripted SDF stub
// Expected results are queued when a ray is sent and popped when the DUT presents a result.
module tb_ray_march_stepper;

  localparam int FP = 32;
  localparam int SW = 7;
  localparam int IDW = 20;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            ray_valid_in;
  logic            ray_ready_out;
  logic [3*FP-1:0] ray_origin_in;
  logic [3*FP-1:0] ray_dir_in;
  logic [IDW-1:0]  ray_id_in;
  logic [3*FP-1:0] query_point_out;
  logic            query_valid_out;
  logic [FP-1:0]   sdf_in;
  logic            res_valid_out;
  logic            res_ready_in;
  logic            res_hit_out;
  logic [FP-1:0]   res_t_out;
  logic [SW-1:0]   res_steps_out;
  logic [IDW-1:0]  res_id_out;

  ray_march_stepper dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .ray_valid_in(ray_valid_in), .ray_ready_out(ray_ready_out),
    .ray_origin_in(ray_origin_in), .ray_dir_in(ray_dir_in), .ray_id_in(ray_id_in),
    .query_point_out(query_point_out), .query_valid_out(query_valid_out), .sdf_in(sdf_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_hit_out(res_hit_out),
    .res_t_out(res_t_out), .res_steps_out(res_steps_out), .res_id_out(res_id_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  // SDF stub: fixed 4-cycle pipeline; drives 0 (a would-be hit) whenever no answer is due.
  bit            pv [4];
  logic [31:0]   pd [4];
  int            n_strobes = 0;
  int            strobe_cyc[$];
  logic [95:0]   strobe_pt[$];
  logic [31:0]   sdf_script[$];
  logic [31:0]   sdf_default = 32'h0;
  int            strobe_base = 0;

  always @(negedge clk_in) begin
    int k;
    sdf_in = pv[3] ? pd[3] : 32'h0;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = query_valid_out;
    pd[0] = 32'h0;
    if (query_valid_out) begin
      k = n_strobes - strobe_base;
      pd[0] = (k < sdf_script.size()) ? sdf_script[k] : sdf_default;
      strobe_cyc.push_back(cyc);
      strobe_pt.push_back(query_point_out);
      n_strobes++;
    end
  end

  typedef struct {
    logic          hit;
    logic [31:0]   t;
    logic [SW-1:0] steps;
    logic [IDW-1:0] id;
  } res_s;

  res_s exp_q[$];
  int tests = 0;
  int fails = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic hit, input logic [31:0] t, input int steps, input int id);
    res_s r;
    r.hit = hit; r.t = t; r.steps = SW'(steps); r.id = IDW'(id);
    exp_q.push_back(r);
  endtask

  task automatic set_script(input logic [31:0] dflt);
    sdf_script.delete();
    sdf_default = dflt;
    strobe_base = n_strobes;
  endtask

  task automatic send_ray(input logic [95:0] o, input logic [95:0] d, input int id);
    int n;
    n = 0;
    while (!ray_ready_out && n < 200) begin tick(); n++; end
    tests++;
    if (ray_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL send_ray_ready id=%0d: ray_ready_out=%b after %0d cycles, required 1", id, ray_ready_out, n);
    end
    ray_origin_in = o;
    ray_dir_in    = d;
    ray_id_in     = IDW'(id);
    ray_valid_in  = 1'b1;
    tick();
    ray_valid_in  = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    int n;
    n = 0;
    while (res_valid_out !== 1'b1 && n < 1000) begin tick(); n++; end
    ok = (res_valid_out === 1'b1);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL result_timeout: res_valid_out=%b after %0d cycles, required 1", res_valid_out, n);
    end
  endtask

  task automatic check_result;
    res_s e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_result: id=%0d hit=%b t=%h steps=%0d, scoreboard empty",
               res_id_out, res_hit_out, res_t_out, res_steps_out);
    end else begin
      e = exp_q.pop_front();
      if (res_hit_out !== e.hit || res_t_out !== e.t || res_steps_out !== e.steps || res_id_out !== e.id) begin
        fails++;
        $display("FAIL result: got id=%0d hit=%b t=%h steps=%0d, required id=%0d hit=%b t=%h steps=%0d",
                 res_id_out, res_hit_out, res_t_out, res_steps_out, e.id, e.hit, e.t, e.steps);
      end
    end
  endtask

  task automatic collect;
    bit ok;
    wait_result(ok);
    if (ok) begin
      check_result();
      res_ready_in = 1'b1;
      tick();
      res_ready_in = 1'b0;
    end
  endtask

  task automatic check_strobes(input string name, input int s0, input int n_exp);
    tests++;
    if (strobe_cyc.size() - s0 != n_exp) begin
      fails++;
      $display("FAIL %s_strobe_count: got %0d, required %0d", name, strobe_cyc.size() - s0, n_exp);
    end
    for (int k = s0 + 1; k < strobe_cyc.size(); k++) begin
      tests++;
      if (strobe_cyc[k] - strobe_cyc[k-1] != 6) begin
        fails++;
        $display("FAIL %s_strobe_spacing[%0d]: got %0d cycles, required 6", name, k - s0, strobe_cyc[k] - strobe_cyc[k-1]);
      end
    end
  endtask

  task automatic check_point(input string name, input int idx, input logic [95:0] exp_pt);
    tests++;
    if (idx >= strobe_pt.size()) begin
      fails++;
      $display("FAIL %s_point[%0d]: no such strobe, required %h", name, idx, exp_pt);
    end else if (strobe_pt[idx] !== exp_pt) begin
      fails++;
      $display("FAIL %s_point[%0d]: got %h, required %h", name, idx, strobe_pt[idx], exp_pt);
    end
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    ray_valid_in = 1'b0; res_ready_in = 1'b0;
    ray_origin_in = '0; ray_dir_in = '0; ray_id_in = '0;
    repeat (3) tick();
    tests++;
    if (ray_ready_out !== 1'b0 || query_valid_out !== 1'b0 || res_valid_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_strobes: ready=%b qv=%b rv=%b, required 0 0 0", ray_ready_out, query_valid_out, res_valid_out);
    end
    tests++;
    if (res_hit_out !== 1'b0 || res_t_out !== '0 || res_steps_out !== '0 || res_id_out !== '0 || query_point_out !== '0) begin
      fails++;
      $display("FAIL reset_data: hit=%b t=%h steps=%0d id=%0d qp=%h, required all 0",
               res_hit_out, res_t_out, res_steps_out, res_id_out, query_point_out);
    end
    rst_n_in = 1'b1;
    repeat (3) tick();
    tests++;
    if (ray_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b, required 1", ray_ready_out);
    end
  endtask

  task automatic test_hit_walk;
    int s0;
    set_script(32'h0);
    sdf_script = '{ONE, ONE, ONE, 32'h0};
    s0 = strobe_cyc.size();
    push_exp(1'b1, 32'h0003_0000, 4, 1);
    send_ray({32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, ONE}, 1);
    collect();
    check_strobes("hit_walk", s0, 4);
    for (int k = 0; k < 4; k++) check_point("hit_walk", s0 + k, {32'h0, 32'h0, 32'(k) << 16});
  endtask

  task automatic test_escape;
    int s0;
    set_script(32'h0004_0000);
    s0 = strobe_cyc.size();
    push_exp(1'b0, 32'h0024_0000, 9, 2);
    send_ray({32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000}, {32'h0000_8000, 32'hFFFF_8000, 32'h0}, 2);
    collect();
    check_strobes("escape", s0, 9);
    check_point("escape", s0, {32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000});
    check_point("escape", s0 + 1, {32'h0003_0000, 32'h0000_0000, 32'hFFFD_0000});
    check_point("escape", s0 + 8, {32'h0011_0000, 32'hFFF2_0000, 32'hFFFD_0000});
  endtask

  task automatic test_max_steps;
    int s0;
    set_script(32'h0000_0200);
    s0 = strobe_cyc.size();
    push_exp(1'b0, 32'h0000_8000, 64, 3);
    send_ray({32'h0, 32'h0, 32'h0}, {ONE, 32'h0, 32'h0}, 3);
    collect();
    check_strobes("max_steps", s0, 64);
  endtask

  task automatic test_negative;
    int s0;
    set_script(ONE);
    sdf_script = '{32'hFFFF_0000};
    s0 = strobe_cyc.size();
    push_exp(1'b1, 32'h0, 1, 4);
    send_ray({32'h0, 32'h0, 32'h0}, {32'h0, ONE, 32'h0}, 4);
    collect();
    check_strobes("negative", s0, 1);
  endtask

  task automatic test_back_to_back;
    bit ok;
    int ns;
    logic [31:0] t0;
    logic [SW-1:0] s0;
    set_script(32'h0);
    push_exp(1'b1, 32'h0, 1, 6);
    send_ray({32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, ONE}, 6);
    wait_result(ok);
    if (ok) begin
      check_result();
      t0 = res_t_out; s0 = res_steps_out; ns = n_strobes;
      for (int k = 0; k < 10; k++) begin
        tick();
        tests++;
        if (res_valid_out !== 1'b1 || ray_ready_out !== 1'b0 || res_t_out !== t0 ||
            res_steps_out !== s0 || res_id_out !== IDW'(6) || n_strobes != ns) begin
          fails++;
          $display("FAIL hold[%0d]: rv=%b ready=%b t=%h steps=%0d id=%0d strobes=%0d, required 1 0 %h %0d 6 %0d",
                   k, res_valid_out, ray_ready_out, res_t_out, res_steps_out, res_id_out, n_strobes, t0, s0, ns);
        end
      end
      set_script(32'h0);
      sdf_script = '{32'h0002_0000, 32'h0};
      push_exp(1'b1, 32'h0002_0000, 2, 7);
      ray_origin_in = '0; ray_dir_in = {32'h0, 32'h0, ONE}; ray_id_in = IDW'(7);
      ray_valid_in = 1'b1;
      res_ready_in = 1'b1;
      tests++;
      if (ray_ready_out !== 1'b0) begin
        fails++;
        $display("FAIL handshake_ready: ray_ready_out=%b in handshake cycle, required 0", ray_ready_out);
      end
      tick();
      res_ready_in = 1'b0;
      tests++;
      if (res_valid_out !== 1'b0 || ray_ready_out !== 1'b1 || query_valid_out !== 1'b0) begin
        fails++;
        $display("FAIL after_handshake: rv=%b ready=%b qv=%b, required 0 1 0", res_valid_out, ray_ready_out, query_valid_out);
      end
      tick();
      ray_valid_in = 1'b0;
      tests++;
      if (query_valid_out !== 1'b1) begin
        fails++;
        $display("FAIL next_ray_issue: query_valid_out=%b two cycles after handshake, required 1", query_valid_out);
      end
      collect();
    end
  endtask

  task automatic test_reset_mid_ray;
    set_script(32'h0);
    sdf_script = '{32'h0};
    send_ray({32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, ONE}, 9);
    tick();
    tick();
    rst_n_in = 1'b0;
    tick();
    tests++;
    if (res_valid_out !== 1'b0 || query_valid_out !== 1'b0 || ray_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: rv=%b qv=%b ready=%b, required 0 0 0", res_valid_out, query_valid_out, ray_ready_out);
    end
    tick();
    rst_n_in = 1'b1;
    set_script(32'h0);
    sdf_script = '{32'h0002_0000, 32'h0};
    push_exp(1'b1, 32'h0002_0000, 2, 5);
    send_ray({32'h0, 32'h0, 32'h0}, {32'h0, 32'h0, ONE}, 5);
    collect();
    repeat (20) tick();
    tests++;
    if (res_valid_out !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL mid_reset_leftover: rv=%b pending=%0d, required 0 0", res_valid_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_hit_walk();
    test_escape();
    test_max_steps();
    test_negative();
    test_back_to_back();
    test_reset_mid_ray();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
